// File: rtl/knn_sequencer.sv
// Control stage ahead of the knn pipeline: streams every training sample against each
// test sample from two 1-cycle-latency memories, captures results and keeps accuracy counts.
module knn_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int LABEL_W  = 2,
  parameter int WAIT_MAX = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           train_size,
  input  logic [ADDR_W-1:0]           test_size,
  output logic [ADDR_W-1:0]           train_addr,
  input  logic [DATA_W+LABEL_W-1:0]   train_rdata,
  output logic [ADDR_W-1:0]           test_addr,
  input  logic [DATA_W+LABEL_W-1:0]   test_rdata,
  output logic                        knn_rst,
  output logic                        knn_vld,
  output logic [DATA_W-1:0]           knn_test_data,
  output logic [DATA_W-1:0]           knn_train_data,
  output logic [LABEL_W-1:0]          knn_label,
  output logic [ADDR_W-1:0]           knn_index,
  input  logic [LABEL_W-1:0]          knn_res,
  input  logic                        knn_res_vld,
  output logic                        res_wr,
  output logic [ADDR_W-1:0]           res_addr,
  output logic [LABEL_W-1:0]          res_label,
  output logic                        res_correct,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [ADDR_W-1:0]           n_correct,
  output logic [ADDR_W-1:0]           n_all
);

  localparam int WORD_W = DATA_W + LABEL_W;
  localparam int WAIT_W = $clog2(WAIT_MAX + 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX);

  typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, NEXT, DONE} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   n_train, n_test, t_idx, k_idx;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [LABEL_W-1:0]  act_label;
  logic                timeout;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    state_nxt      = state;
    train_addr     = '0;
    test_addr      = '0;
    knn_rst        = 1'b0;
    knn_vld        = 1'b0;
    knn_test_data  = '0;
    knn_train_data = '0;
    knn_label      = '0;
    knn_index      = '0;
    res_wr         = 1'b0;
    res_addr       = '0;
    res_label      = '0;
    res_correct    = 1'b0;
    done           = 1'b0;
    timeout        = 1'b0;
    busy           = (state != IDLE);
    case (state)
      IDLE: begin
        knn_rst = 1'b1;
        if (start)
          state_nxt = (train_size == '0 || test_size == '0) ? DONE : LOAD;
      end
      LOAD: begin
        knn_rst   = 1'b1;
        test_addr = t_idx;
        state_nxt = STREAM;
      end
      STREAM: begin
        // Address k+1 is issued now so its data lands exactly when k advances.
        test_addr      = t_idx;
        train_addr     = k_idx + ADDR_ONE;
        knn_vld        = 1'b1;
        knn_index      = k_idx;
        knn_train_data = train_rdata[DATA_W-1:0];
        knn_label      = train_rdata[WORD_W-1:DATA_W];
        knn_test_data  = test_rdata[DATA_W-1:0];
        if (k_idx == n_train - ADDR_ONE)
          state_nxt = DRAIN;
      end
      DRAIN: begin
        if (knn_res_vld) begin
          res_wr      = 1'b1;
          res_addr    = t_idx;
          res_label   = knn_res;
          res_correct = (knn_res == act_label);
          state_nxt   = NEXT;
        end else if (wait_cnt == WAIT_LAST) begin
          res_wr    = 1'b1;
          res_addr  = t_idx;
          timeout   = 1'b1;
          state_nxt = NEXT;
        end
      end
      NEXT: begin
        knn_rst   = 1'b1;
        state_nxt = (t_idx == n_test - ADDR_ONE) ? DONE : LOAD;
      end
      DONE: begin
        knn_rst   = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        knn_rst   = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      n_train   <= '0;
      n_test    <= '0;
      t_idx     <= '0;
      k_idx     <= '0;
      wait_cnt  <= '0;
      act_label <= '0;
      n_correct <= '0;
      n_all     <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            n_train   <= train_size;
            n_test    <= test_size;
            n_correct <= '0;
            n_all     <= '0;
            err       <= 1'b0;
            t_idx     <= '0;
          end
        end
        LOAD: k_idx <= '0;
        STREAM: begin
          k_idx    <= k_idx + ADDR_ONE;
          wait_cnt <= '0;
          if (k_idx == '0)
            act_label <= test_rdata[WORD_W-1:DATA_W];
        end
        DRAIN: begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
          if (res_wr) begin
            n_all <= n_all + ADDR_ONE;
            if (res_correct)
              n_correct <= n_correct + ADDR_ONE;
          end
          if (timeout)
            err <= 1'b1;
        end
        NEXT: begin
          if (state_nxt == LOAD)
            t_idx <= t_idx + ADDR_ONE;
        end
        default: ;
      endcase
      // A result strobe outside DRAIN is a protocol error; it overrides the clear on start.
      if (knn_res_vld && state != DRAIN)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_knn_sequencer.sv
// Scoreboard bench for knn_sequencer: a behavioural knn stub plus memory models, expected
// knn beats and result records queued from a per-run reference model, checked by a monitor.
module tb_knn_sequencer;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 32;
  localparam int LABEL_W  = 2;
  localparam int WAIT_MAX = 8;
  localparam int WORD_W   = DATA_W + LABEL_W;

  typedef struct {
    int                 idx;
    logic [DATA_W-1:0]  train_feat;
    logic [LABEL_W-1:0] train_lbl;
    logic [DATA_W-1:0]  test_feat;
  } beat_t;

  typedef struct {
    int                 addr;
    logic [LABEL_W-1:0] lbl;
    logic               correct;
    int                 gap;
  } rec_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [ADDR_W-1:0]   train_size = '0;
  logic [ADDR_W-1:0]   test_size = '0;
  logic [ADDR_W-1:0]   train_addr, test_addr;
  logic [WORD_W-1:0]   train_rdata = '0;
  logic [WORD_W-1:0]   test_rdata = '0;
  logic                knn_rst, knn_vld;
  logic [DATA_W-1:0]   knn_test_data, knn_train_data;
  logic [LABEL_W-1:0]  knn_label;
  logic [ADDR_W-1:0]   knn_index;
  logic [LABEL_W-1:0]  knn_res = '0;
  logic                knn_res_vld = 1'b0;
  logic                res_wr;
  logic [ADDR_W-1:0]   res_addr;
  logic [LABEL_W-1:0]  res_label;
  logic                res_correct, busy, done, err;
  logic [ADDR_W-1:0]   n_correct, n_all;

  knn_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LABEL_W(LABEL_W), .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .train_size(train_size), .test_size(test_size),
    .train_addr(train_addr), .train_rdata(train_rdata),
    .test_addr(test_addr), .test_rdata(test_rdata),
    .knn_rst(knn_rst), .knn_vld(knn_vld), .knn_test_data(knn_test_data),
    .knn_train_data(knn_train_data), .knn_label(knn_label), .knn_index(knn_index),
    .knn_res(knn_res), .knn_res_vld(knn_res_vld),
    .res_wr(res_wr), .res_addr(res_addr), .res_label(res_label), .res_correct(res_correct),
    .busy(busy), .done(done), .err(err), .n_correct(n_correct), .n_all(n_all)
  );

  always #5 clk = ~clk;

  logic [WORD_W-1:0]  train_mem [256];
  logic [WORD_W-1:0]  test_mem  [256];
  int                 delay     [256];   // DRAIN cycle of the result strobe, 0 = never
  logic [LABEL_W-1:0] res_of    [256];
  bit                 spur_en = 1'b0;
  int                 spur_t = 0, spur_k = 0;

  beat_t beat_q [$];
  rec_t  rec_q  [$];
  int    n_checks = 0, n_fail = 0, done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Synchronous-read memories with one cycle of latency.
  always @(posedge clk) begin
    train_rdata <= train_mem[train_addr];
    test_rdata  <= test_mem[test_addr];
  end

  // knn stub: answers on the delay-th DRAIN cycle of each test, optionally strobes during STREAM.
  int dcnt = 0, cur_t = 0;
  always @(posedge clk) begin
    #1;
    knn_res_vld = 1'b0;
    knn_res     = '0;
    if (knn_vld) begin
      cur_t = int'(test_addr);
      dcnt  = 0;
      if (spur_en && cur_t == spur_t && int'(knn_index) == spur_k) begin
        knn_res_vld = 1'b1;
        knn_res     = 2'(cur_t + 1);
      end
    end else if (!knn_rst) begin
      dcnt++;
      if (delay[cur_t] != 0 && dcnt == delay[cur_t]) begin
        knn_res_vld = 1'b1;
        knn_res     = res_of[cur_t];
      end
    end else begin
      dcnt = 0;
    end
  end

  // Monitor: pops and compares whenever the DUT presents a knn beat or a result record.
  int since_vld = 0;
  always @(negedge clk) begin
    if (knn_vld) begin
      since_vld = 0;
      if (beat_q.size() == 0) begin
        check("unexpected knn_vld", 64'(knn_vld), 64'(0));
      end else begin
        beat_t b;
        b = beat_q.pop_front();
        check("knn_index", 64'(knn_index), 64'(b.idx));
        check("knn_train_data", 64'(knn_train_data), 64'(b.train_feat));
        check("knn_label", 64'(knn_label), 64'(b.train_lbl));
        check("knn_test_data", 64'(knn_test_data), 64'(b.test_feat));
      end
    end else begin
      since_vld++;
    end
    if (res_wr) begin
      if (rec_q.size() == 0) begin
        check("unexpected res_wr", 64'(res_wr), 64'(0));
      end else begin
        rec_t r;
        r = rec_q.pop_front();
        check("res_addr", 64'(res_addr), 64'(r.addr));
        check("res_label", 64'(res_label), 64'(r.lbl));
        check("res_correct", 64'(res_correct), 64'(r.correct));
        check("result latency", 64'(since_vld), 64'(r.gap));
      end
    end
    if (done) done_cnt++;
  end

  // mode: 0 random, 1 all timeouts, 2 start while busy, 3 spurious strobe, 4 reset at k=1, 5 basic
  task automatic run_case(input int ntr, input int nte, input int mode);
    int exp_all, exp_cor, cyc;
    bit exp_err, poked;
    for (int i = 0; i < 256; i++) begin
      train_mem[i] = {2'($urandom_range(0, 3)), 32'($urandom)};
      test_mem[i]  = {2'($urandom_range(0, 3)), 32'($urandom)};
      delay[i]     = (mode == 1) ? 0 : (mode == 5) ? 4 : int'($urandom_range(1, 7));
      res_of[i]    = (mode == 5) ? train_mem[0][WORD_W-1:DATA_W] : 2'($urandom_range(0, 3));
    end
    spur_en = (mode == 3);
    spur_t  = 0;
    spur_k  = 1;
    exp_err = (mode == 1) || (mode == 3);
    exp_all = 0;
    exp_cor = 0;
    if (ntr > 0 && nte > 0) begin
      for (int t = 0; t < nte; t++) begin
        if (mode == 4 && t > 0) break;
        for (int k = 0; k < ntr; k++) begin
          if (mode == 4 && k > 1) break;
          beat_q.push_back('{k, train_mem[k][DATA_W-1:0], train_mem[k][WORD_W-1:DATA_W],
                             test_mem[t][DATA_W-1:0]});
        end
        if (mode != 4) begin
          rec_t r;
          r.addr    = t;
          r.lbl     = (delay[t] == 0) ? '0 : res_of[t];
          r.correct = (delay[t] != 0) && (res_of[t] == test_mem[t][WORD_W-1:DATA_W]);
          r.gap     = (delay[t] == 0) ? WAIT_MAX + 1 : delay[t];
          rec_q.push_back(r);
          exp_all++;
          if (r.correct) exp_cor++;
        end
      end
    end
    done_cnt = 0;
    @(negedge clk);
    train_size = 8'(ntr);
    test_size  = 8'(nte);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    train_size = 8'($urandom);
    test_size  = 8'($urandom);
    if (mode == 4) begin
      cyc = 0;
      while (!(knn_vld && knn_index == 8'd1) && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      check("reached k=1 before reset", 64'(knn_index), 64'(1));
      rst = 1'b1;
      @(negedge clk);
      check("reset knn_rst", 64'(knn_rst), 64'(1));
      check("reset busy", 64'(busy), 64'(0));
      check("reset knn_vld", 64'(knn_vld), 64'(0));
      check("reset n_all", 64'(n_all), 64'(0));
      check("reset n_correct", 64'(n_correct), 64'(0));
      check("reset err", 64'(err), 64'(0));
      rst = 1'b0;
      check("reset beats left", 64'(beat_q.size()), 64'(0));
      return;
    end
    poked = 1'b0;
    cyc   = 0;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (start) start = 1'b0;
      if (mode == 2 && !poked && knn_vld && knn_index == 8'd1) begin
        start      = 1'b1;
        train_size = 8'(ntr + 5);
        test_size  = 8'(nte + 3);
        poked      = 1'b1;
      end
    end
    check("done pulse seen", 64'(done), 64'(1));
    if (ntr == 0 || nte == 0) check("zero-size done latency", 64'(cyc), 64'(0));
    @(negedge clk);
    check("busy after done", 64'(busy), 64'(0));
    check("done pulse count", 64'(done_cnt), 64'(1));
    check("n_all", 64'(n_all), 64'(exp_all));
    check("n_correct", 64'(n_correct), 64'(exp_cor));
    check("err", 64'(err), 64'(exp_err));
    check("beats left", 64'(beat_q.size()), 64'(0));
    check("records left", 64'(rec_q.size()), 64'(0));
    spur_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      train_mem[i] = '0;
      test_mem[i]  = '0;
      delay[i]     = 1;
      res_of[i]    = '0;
    end
    repeat (3) @(negedge clk);
    check("init knn_rst", 64'(knn_rst), 64'(1));
    check("init busy", 64'(busy), 64'(0));
    check("init done", 64'(done), 64'(0));
    check("init res_wr", 64'(res_wr), 64'(0));
    check("init knn_vld", 64'(knn_vld), 64'(0));
    check("init err", 64'(err), 64'(0));
    check("init n_all", 64'(n_all), 64'(0));
    check("init n_correct", 64'(n_correct), 64'(0));
    rst = 1'b0;

    run_case(3, 2, 5);
    for (int i = 0; i < 4; i++)
      run_case(int'($urandom_range(1, 12)), int'($urandom_range(1, 5)), 0);
    run_case(3, 2, 1);
    run_case(0, 3, 0);
    run_case(4, 0, 0);
    run_case(4, 2, 2);
    run_case(5, 2, 3);
    run_case(4, 3, 4);
    run_case(3, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/knn_sequencer.md
Name: knn_sequencer

Overview:
- Synthesizable control stage directly upstream of the knn pipeline.
- Reads training and test samples from two single-port synchronous-read memories, each with one-cycle read latency and 34-bit words {label[1:0], features[31:0]}.
- Streams every training sample against each test sample into knn, resets knn between test samples, and captures each res/res_vld result.
- Writes per-sample result records and keeps running accuracy counters; replaces the behavioural control loop for on-chip runs.

Parameters:
- ADDR_W, 8, memory address and counter width.
- DATA_W, 32, feature word width.
- LABEL_W, 2, class label width.
- WAIT_MAX, 64, maximum DRAIN cycles allowed for res_vld before a timeout.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run; sampled only in IDLE.
- train_size  in  ADDR_W  number of training samples; latched on accepted start.
- test_size  in  ADDR_W  number of test samples; latched on accepted start.
- train_addr  out  ADDR_W  training memory read address.
- train_rdata  in  DATA_W+LABEL_W  training memory read data, one cycle after address.
- test_addr  out  ADDR_W  test memory read address.
- test_rdata  in  DATA_W+LABEL_W  test memory read data, one cycle after address.
- knn_rst  out  1  reset to the knn pipeline.
- knn_vld  out  1  qualifies the knn data outputs.
- knn_test_data  out  DATA_W  current test features.
- knn_train_data  out  DATA_W  training features.
- knn_label  out  LABEL_W  training label.
- knn_index  out  ADDR_W  training sample index.
- knn_res  in  LABEL_W  predicted label from knn.
- knn_res_vld  in  1  one-cycle result strobe from knn.
- res_wr  out  1  result record write strobe.
- res_addr  out  ADDR_W  result record index, equal to the test index.
- res_label  out  LABEL_W  predicted label; 0 on timeout.
- res_correct  out  1  predicted label equals actual label.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse at end of run.
- err  out  1  sticky protocol/timeout error; cleared on accepted start.
- n_correct  out  ADDR_W  count of correct classifications.
- n_all  out  ADDR_W  count of classified test samples.

Behaviour:
- Reset: state=IDLE. All outputs 0 except knn_rst=1. Counters and err are 0. Reset mid-run aborts immediately with no record written.
- States: IDLE, LOAD, STREAM, DRAIN, NEXT, DONE.
- IDLE
  - start=1: latch sizes, clear n_correct/n_all/err, set t=0.
  - If either size is 0, go to DONE; otherwise go to LOAD.
  - start outside IDLE is ignored.
- LOAD (1 cycle): test_addr=t, train_addr=0, k=0; go to STREAM.
- STREAM (train_size cycles, k=0..N-1)
  - test_addr is held at t; train_addr=k+1.
  - train_rdata and test_rdata are valid for train index k and test index t.
  - knn_vld=1, knn_index=k, knn_train_data/knn_label come from train_rdata, knn_test_data from test_rdata[DATA_W-1:0].
  - On k=0, latch the actual label test_rdata[top LABEL_W bits].
  - After k=N-1, go to DRAIN. train_addr beyond N-1 is don't-care.
- DRAIN
  - knn_vld=0; wait counter runs from 0.
  - On knn_res_vld: res_wr=1 that cycle with res_addr=t, res_label=knn_res, res_correct=(knn_res==latched label). Increment n_all, and n_correct if correct. Go to NEXT.
  - If the counter reaches WAIT_MAX with no res_vld: set err, write the record with res_label=0 and res_correct=0, increment n_all, go to NEXT.
- NEXT (1 cycle)
  - If t==test_size-1, go to DONE; otherwise t=t+1 and go to LOAD.
- DONE (1 cycle): done=1, then go to IDLE. Counters hold until the next start.
- knn_rst=1 in IDLE, LOAD, NEXT and DONE; 0 in STREAM and DRAIN.
- Outside STREAM, all knn data outputs are 0.
- res_vld arriving in any state other than DRAIN: set err, ignore the value, write no record.
- Counter widths ADDR_W; no wrap is possible since sizes are at most 2^ADDR_W-1.
- Per test sample the cost is 1 (LOAD) + N (STREAM) + DRAIN latency + 1 (NEXT) cycles.

Test Plan:
- Basic run: train_size=3, test_size=2; knn model asserts res_vld 4 cycles into DRAIN with res=label of training[0].
  - Required: knn_index sequence 0,1,2 per test, pairing matches memory contents.
  - Two res_wr strobes at res_addr 0 and 1; n_all=2; n_correct matches the labels; one done pulse; busy falls the cycle after done.
- Zero size: start with train_size=0 (and separately test_size=0).
  - Required: the next cycle is DONE, done pulses, no res_wr, n_all=0, err=0.
- Timeout: model never asserts res_vld, WAIT_MAX=8.
  - Required: err=1; record written with res_label=0 and res_correct=0 after 8 DRAIN cycles; the run continues to the next test.
- Start while busy: pulse start mid-STREAM with different sizes.
  - Required: ignored; the original sizes complete.
- Reset mid-STREAM at k=1.
  - Required: next cycle state IDLE, knn_rst=1, counters 0, no res_wr; a subsequent start runs cleanly.
- Spurious res_vld during STREAM.
  - Required: err=1, no record written, n_all unchanged; the sequence continues normally.
